// File: rtl/gp_timer_multi.sv
// Multi-channel down-counting timer: CHANNELS independent WIDTH-bit timers with
// periodic/one-shot mode, per-channel interrupt enable and W1C status flag.
module gp_timer_multi #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int CH_AW    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [CH_AW+1:0]    addr,
  input  logic                wr_en,
  input  logic [WIDTH-1:0]    wdata,
  output logic [WIDTH-1:0]    rdata,
  output logic [CHANNELS-1:0] irq,
  output logic                irq_n
);

  localparam int NSLOT = 1 << CH_AW;

  logic [CH_AW-1:0]            ch_sel;
  logic [1:0]                  reg_sel;
  logic [NSLOT-1:0][WIDTH-1:0] slot_rdata;

  assign ch_sel  = addr[CH_AW+1:2];
  assign reg_sel = addr[1:0];

  // One slot per decodable channel index; slots past CHANNELS read as zero.
  for (genvar i = 0; i < NSLOT; i++) begin : g_ch
    if (i < CHANNELS) begin : g_on
      logic             en_q, mode_q, ie_q, flag_q;
      logic [WIDTH-1:0] reload_q, count_q;
      logic             sel, term;

      assign sel  = wr_en && (ch_sel == CH_AW'(i));
      assign term = en_q && tick && (count_q == '0);

      always_ff @(posedge clk) begin
        if (rst) begin
          en_q     <= 1'b0;
          mode_q   <= 1'b0;
          ie_q     <= 1'b0;
          flag_q   <= 1'b0;
          reload_q <= '0;
          count_q  <= '0;
        end else begin
          // A CTRL write beats the one-shot self-disable in the same cycle.
          if (sel && reg_sel == 2'd0) begin
            en_q   <= wdata[0];
            mode_q <= wdata[1];
            ie_q   <= wdata[2];
          end else if (term && mode_q) begin
            en_q <= 1'b0;
          end

          if (sel && reg_sel == 2'd1)
            reload_q <= wdata;

          // Disabled channels track reload so enabling starts a full period.
          if (!en_q)
            count_q <= reload_q;
          else if (tick) begin
            if (count_q != '0)
              count_q <= count_q - WIDTH'(1);
            else if (!mode_q)
              count_q <= reload_q;
          end

          if (term)
            flag_q <= 1'b1;
          else if (sel && reg_sel == 2'd3 && wdata[0])
            flag_q <= 1'b0;
        end
      end

      assign slot_rdata[i] = (reg_sel == 2'd0) ? {{(WIDTH-3){1'b0}}, ie_q, mode_q, en_q} :
                             (reg_sel == 2'd1) ? reload_q :
                             (reg_sel == 2'd2) ? count_q :
                                                 {{(WIDTH-1){1'b0}}, flag_q};
      assign irq[i] = flag_q & ie_q;
    end else begin : g_off
      assign slot_rdata[i] = '0;
    end
  end

  assign rdata = slot_rdata[ch_sel];
  assign irq_n = ~|irq;

endmodule

// File: doc/gp_timer_multi.md
# gp_timer_multi

Parametrised multi-channel down-counting timer, the successor to the single 16-bit periodic timer. Provides CHANNELS independent WIDTH-bit timers, each with periodic or one-shot mode, per-channel interrupt enable and sticky write-1-to-clear status. All logic runs on one system clock; counting advances on a single-cycle `tick` strobe. Sits behind bus_ctrl as a register-mapped peripheral and drives one combined active-low interrupt toward the CPU interrupt encoder.

## Interface
- WIDTH, 16: counter/reload/data width; legal range 3..32.
- CHANNELS, 4: number of timer channels; legal range 1..16.
- CH_AW, 2: channel-index address bits; must satisfy 2^CH_AW >= CHANNELS.

- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  count-enable strobe, sampled on clk; one count step per cycle it is high.
- addr  in  CH_AW+2  addr[CH_AW+1:2] = channel, addr[1:0] = register.
- wr_en  in  1  write strobe; one write per cycle it is high.
- wdata  in  WIDTH  write data.
- rdata  out  WIDTH  combinational read data for addr.
- irq  out  CHANNELS  per-channel request, irq[i] = flag[i] & ie[i].
- irq_n  out  1  ~|irq.

## Operation
- Per-channel registers: reg 0 CTRL {ie[2], mode[1] (0 periodic, 1 one-shot), en[0]}, other bits read 0; reg 1 RELOAD (R/W); reg 2 COUNT (read-only, writes ignored); reg 3 STATUS {flag[0]}, write 1 to bit 0 clears, write 0 has no effect.
- Channel index >= CHANNELS: reads return 0, writes ignored.
- Disabled (en=0): count <= reload every cycle; no flag activity.
- Enabled, tick=0: count holds.
- Enabled, tick=1, count != 0: count <= count - 1.
- Enabled, tick=1, count == 0 (terminal event): flag <= 1; periodic: count <= reload; one-shot: en <= 0 (count follows reload from the next cycle).
- Period = reload+1 ticks. reload=0 periodic: terminal event on every tick.
- RELOAD written while enabled: current count unaffected; new value used at the next terminal reload.
- CTRL written with en=1 while en already 1: mode/ie updated, count not disturbed.
- Terminal event and STATUS W1C in the same cycle: set wins, flag stays 1.
- One-shot terminal event and CTRL write in the same cycle: the CTRL write wins for en.
- Channels fully independent; simultaneous terminal events set each flag.
- Subtraction is modulo 2^WIDTH, but count never underflows since 0 is terminal.

## Timing
- Reset (rst high at a clk edge): ctrl=0, reload=0, count=0, flag=0 for all channels; irq=0, irq_n=1 from that edge; rst overrides any concurrent write or tick.
- Register writes take effect at the clk edge where wr_en is high; readable next cycle.
- rdata combinational from addr and current register state (zero wait states).
- flag set at the edge ending the terminal-event cycle; irq/irq_n change combinationally from flag/ie flops, i.e. valid the cycle after the terminal tick.
- Enable write with en 0->1: count already equals reload (disabled tracking); first decrement on the first tick after the write edge.
- rst asserted mid-count: all channels return to reset state at that edge; no flag from a coincident terminal event.

## Test plan
- Reset: drive writes and tick during rst -> after release all reads 0, irq_n=1.
- Periodic: ch0 RELOAD=3, CTRL=0b101, tick every cycle -> COUNT 3,2,1,0,3...; flag/irq_n low 4 ticks after enable edge; clear via STATUS=1 -> irq_n=1, reasserts 4 ticks later.
- One-shot: ch1 RELOAD=2, CTRL=0b111 -> one flag after 3 ticks, CTRL reads 0b110, COUNT reads 2, no further flags over 20 ticks.
- Sparse tick and reload change: ch2 RELOAD=5 periodic, tick every 3rd cycle -> flag after 6 ticks (18 cycles); write RELOAD=1 mid-count -> current period unchanged, subsequent periods 2 ticks.
- Collisions: W1C STATUS same cycle as terminal event -> flag remains 1; reload=0 periodic -> flag every tick; ie=0 -> flag=1 but irq[i]=0.
- Parametrisation: WIDTH=32, CHANNELS=3 -> RELOAD=0xFFFFFFFF loads/reads correctly; addr channel 3 reads 0 and writes ignored; all three channels interrupt independently.
